// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared constants and helpers for the programmable sequence detector
package seqdet_pkg;

    // Reset-time pattern 10110, right-aligned, first received bit at [len-1]
    localparam logic [7:0] DEF_PAT_C = 8'b0001_0110;
    localparam int         DEF_LEN_C = 5;

    // Detection mode encoding as seen on the overlap input
    localparam logic OVL  = 1'b1;
    localparam logic NOVL = 1'b0;

    // Width needed to hold a length in 0..pat_w inclusive
    function automatic int lw_of(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with priority synchronous clear
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear wins over increment; increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seqdet_prog.sv
// rtl/seqdet_prog.sv - programmable serial pattern detector with saturating match count
module seqdet_prog
    import seqdet_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
    parameter int               DEF_LEN = DEF_LEN_C,
    parameter int               CNT_W   = 8,
    localparam int              LW      = lw_of(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LW-1:0]    len_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LW-1:0] FULL_LEN  = LW'(PAT_W);
    localparam logic [LW-1:0] RESET_LEN = LW'(DEF_LEN);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LW-1:0]    len_q,  len_d;
    logic             z_q,    z_d;

    logic [PAT_W-1:0] hist_n;
    logic [LW-1:0]    fill_n;
    logic [PAT_W:0]   mask_w;
    logic [PAT_W-1:0] mask;
    logic             hit;
    logic             match;

    // Candidate history after shifting in the current bit, and masked compare
    // against the low len bits of the pattern; one extra mask bit lets len==PAT_W
    // produce an all-ones mask without overflowing the shift.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], x};
        fill_n = (fill_q == FULL_LEN) ? fill_q : fill_q + 1'b1;
        mask_w = ({{PAT_W{1'b0}}, 1'b1} << len_q) - {{PAT_W{1'b0}}, 1'b1};
        mask   = mask_w[PAT_W-1:0];
        hit    = (len_q != '0) && (fill_n >= len_q) &&
                 (((hist_n ^ pat_q) & mask) == '0);
        match  = x_valid && !pat_load && hit;
    end

    // Next-state: load flushes history, valid bits shift and may match
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        z_d    = 1'b0;
        if (pat_load) begin
            pat_d  = pat_in;
            len_d  = (len_in > FULL_LEN) ? FULL_LEN : len_in;
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = hist_n;
            fill_d = fill_n;
            if (hit) begin
                z_d = 1'b1;
                // Non-overlapping: the next match must be built from fresh bits only
                if (overlap == NOVL) begin
                    fill_d = '0;
                end
            end
        end
    end

    // Detector state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= RESET_LEN;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            z_q    <= z_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc_i(match),
        .clr_i(cnt_clr),
        .cnt_o(match_cnt)
    );

    assign z = z_q;

endmodule

// File: tb/tb_seqdet_prog.sv
// tb/tb_seqdet_prog.sv - self-checking bench for seqdet_prog with reference model
module tb_seqdet_prog;

    localparam int PAT_W = 8;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             x, x_valid, overlap, pat_load, cnt_clr;
    logic [PAT_W-1:0] pat_in;
    logic [LW-1:0]    len_in;
    logic             z, z2;
    logic [7:0]       cnt8;
    logic [1:0]       cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seqdet_prog #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
        .z(z), .match_cnt(cnt8)
    );

    seqdet_prog #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
        .z(z2), .match_cnt(cnt2)
    );

    // Reference model: bits received since the last flush, compared to the pattern
    bit         win[$];
    logic [7:0] m_pat;
    int         m_len;
    logic       m_z;
    int         m_cnt8, m_cnt2;

    always @(posedge clk or negedge rst_n) begin
        bit m;
        m = 1'b0;
        if (!rst_n) begin
            win.delete();
            m_pat = 8'b0001_0110; m_len = 5; m_z = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            if (pat_load) begin
                m_pat = pat_in;
                m_len = (int'(len_in) > PAT_W) ? PAT_W : int'(len_in);
                win.delete();
            end else if (x_valid) begin
                win.push_back(x);
                if (win.size() > PAT_W) void'(win.pop_front());
                if (m_len != 0 && win.size() >= m_len) begin
                    m = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (win[win.size()-1-i] != m_pat[i]) m = 1'b0;
                end
                if (m && !overlap) win.delete();
            end
            m_z = m;
            if (cnt_clr) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (m) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        checks += 4;
        if (z !== m_z) begin
            failures++; $display("FAIL model_z t=%0t got=%b exp=%b", $time, z, m_z);
        end
        if (z2 !== m_z) begin
            failures++; $display("FAIL model_z2 t=%0t got=%b exp=%b", $time, z2, m_z);
        end
        if (cnt8 !== 8'(m_cnt8)) begin
            failures++; $display("FAIL model_cnt8 t=%0t got=%0d exp=%0d", $time, cnt8, m_cnt8);
        end
        if (cnt2 !== 2'(m_cnt2)) begin
            failures++; $display("FAIL model_cnt2 t=%0t got=%0d exp=%0d", $time, cnt2, m_cnt2);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Feed n bits, first bit is bits[n-1]; mask[i] records z after bit i
    task automatic send_bits(input logic [31:0] bits, input int n, output logic [31:0] mask);
        mask = '0;
        for (int i = 0; i < n; i++) begin
            x = bits[n-1-i]; x_valid = 1'b1;
            @(posedge clk); #1;
            mask[i] = z;
        end
        x_valid = 1'b0; x = 1'b0;
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        pat_in = p; len_in = l; pat_load = 1'b1;
        @(posedge clk); #1;
        pat_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] mk;

    initial begin
        rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = '0; len_in = '0; cnt_clr = 1'b0;
        #1;
        chk("reset_z", {31'b0, z}, 32'd0);
        chk("reset_cnt", {24'b0, cnt8}, 32'd0);
        #14 rst_n = 1'b1;
        #1;

        // Default pattern 10110, overlapping
        send_bits(32'b010110010110101100, 18, mk);
        chk("default_stream_pulses", mk, 32'h0001_0820);
        chk("default_stream_cnt", {24'b0, cnt8}, 32'd3);

        do_reset(); overlap = 1'b1;
        send_bits(32'b10110110, 8, mk);
        chk("ovl_pulses", mk, 32'h90);
        chk("ovl_cnt", {24'b0, cnt8}, 32'd2);

        do_reset(); overlap = 1'b0;
        send_bits(32'b10110110, 8, mk);
        chk("novl_pulses", mk, 32'h10);
        chk("novl_cnt", {24'b0, cnt8}, 32'd1);

        // Full-width pattern, and the clamped length
        do_reset(); overlap = 1'b1;
        load(8'hFF, 4'd8);
        send_bits(32'hFFF, 12, mk);
        chk("len8_pulses", mk, 32'hF80);
        load(8'hFF, 4'd15);
        send_bits(32'hFFF, 12, mk);
        chk("len15_pulses", mk, 32'hF80);

        // Gaps inside the pattern
        do_reset();
        send_bits(32'b10, 2, mk);
        chk("gap_first", mk, 32'h0);
        idle(3);
        send_bits(32'b110, 3, mk);
        chk("gap_pulse", mk, 32'h4);
        chk("gap_cnt", {24'b0, cnt8}, 32'd1);

        // Load mid-pattern discards partial history
        do_reset();
        send_bits(32'b101, 3, mk);
        load(8'h16, 4'd5);
        send_bits(32'b10, 2, mk);
        chk("load_flush_nopulse", mk, 32'h0);
        send_bits(32'b110, 3, mk);
        chk("load_then_match", mk, 32'h4);

        // Saturation on the narrow counter, then clear beating a match
        do_reset(); overlap = 1'b0;
        send_bits({7'b0, 25'b1011010110101101011010110}, 25, mk);
        chk("sat_cnt2", {30'b0, cnt2}, 32'd3);
        chk("sat_cnt8", {24'b0, cnt8}, 32'd5);
        send_bits(32'b1011, 4, mk);
        x = 1'b0; x_valid = 1'b1; cnt_clr = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0; cnt_clr = 1'b0;
        chk("clr_match_z", {31'b0, z}, 32'd1);
        chk("clr_match_cnt8", {24'b0, cnt8}, 32'd0);
        chk("clr_match_cnt2", {30'b0, cnt2}, 32'd0);

        // Async reset between edges while z is high
        do_reset(); overlap = 1'b1;
        load(8'h07, 4'd3);
        send_bits(32'b111, 3, mk);
        chk("pre_async_pulse", mk, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_z", {31'b0, z}, 32'd0);
        chk("async_cnt", {24'b0, cnt8}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_bits(32'b10110, 5, mk);
        chk("post_async_default", mk, 32'h10);

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pat_load = ($urandom_range(0, 29) == 0);
            pat_in   = 8'($urandom);
            len_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 4));
            x        = 1'($urandom);
            x_valid  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) overlap = ~overlap;
            cnt_clr  = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        pat_load = 1'b0; x_valid = 1'b0; cnt_clr = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seqdet_prog.md
# seqdet_prog

Programmable serial sequence detector, the parametrised successor to the fixed 10110 `seqdet`. It scans a 1-bit serial stream for a runtime-loadable pattern of 1..PAT_W bits, in either overlapping or non-overlapping mode. It emits a one-cycle match pulse and keeps a saturating match count. It sits on serial input paths as a framing/sync-word detector and as a bench-reusable golden checker.

## Interface
Parameters:
- `PAT_W`, 8: maximum pattern length in bits (>= 2).
- `DEF_PAT`, 8'b0001_0110: pattern loaded at reset, right-aligned.
- `DEF_LEN`, 5: pattern length at reset (reset pattern = 10110).
- `CNT_W`, 8: match counter width.

Ports (LW = $clog2(PAT_W+1)):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is sampled only when high.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- `pat_load`  in  1  load `pat_in`/`len_in`, flush history.
- `pat_in`  in  PAT_W  new pattern, right-aligned; bit [len-1] is the first bit received.
- `len_in`  in  LW  new length.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `z`  out  1  registered match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.

## Operation
- State: `hist[PAT_W-1:0]` shift register, `fill` (0..PAT_W, saturating), `pat`, `len`, `match_cnt`, `z`.
- Reset (async, `rst_n` low) sets `hist`=0, `fill`=0, `pat`=DEF_PAT, `len`=DEF_LEN, `match_cnt`=0, `z`=0.
- `pat_load` high has priority over `x_valid`:
  - `pat`<=`pat_in`.
  - `len`<=`len_in` clamped to PAT_W.
  - `hist`, `fill` and `z` cleared.
  - `x` is ignored that cycle.
- Each cycle with `x_valid` high and no load:
  - `hist_n` = {hist[PAT_W-2:0], x}.
  - `fill_n` = min(fill+1, PAT_W).
  - Match when `len`!=0, `fill_n`>=`len`, and `hist_n[len-1:0]`==`pat[len-1:0]`.
- On a match:
  - `z`<=1.
  - `match_cnt` increments unless already all-ones.
  - Non-overlap mode: `fill`<=0, so the next match needs `len` fresh bits.
  - Overlap mode: `fill` keeps advancing.
- Cycles with `x_valid` low hold `hist`/`fill` and drive `z`<=0.
- `len`==0 disables detection. `hist` still shifts.
- `cnt_clr` beats a simultaneous match: count goes to 0, and that match is not counted. `z` still pulses.
- Mode change mid-stream takes effect on the next sampled bit. History is not flushed.

## Timing
- Latency: `z` is high for exactly the one cycle after the rising edge that samples the final pattern bit.
- Back-to-back matches, possible in overlap mode with period < `len`, give consecutive `z` pulses.
- `match_cnt` updates on the same edge as `z`.
- Load → first possible match is `len` valid cycles later.
- `rst_n` asserted mid-pattern clears immediately, without waiting for `clk`. Deassertion must be synchronised upstream.
- There is no combinational path from inputs to outputs.

## Structure
- Package `seqdet_pkg`:
  - Function for LW.
  - Localparam defaults for DEF_PAT/DEF_LEN.
  - Mode encoding constants OVL=1, NOVL=0.
- Sub-module `sat_counter` (param width; inc, clr with clr priority; saturate at all-ones) implements `match_cnt`.
- The comparator is a masked compare: mask = (1<<len)-1. No per-length FSM.

## Test plan
- Reset defaults, overlap=1, x_valid=1, `rst_n` released at 15 ns, 10 ns clock. Stream 0,1,0,1,1,0,0,1,0,1,1,0,1,0,1,1,0,0 → `z` pulses after bits 6, 12, 17 (1-based); `match_cnt`=3.
- Stream 1,0,1,1,0,1,1,0:
  - overlap=1 → 2 pulses, the second 3 bits after the first.
  - overlap=0 → 1 pulse, `match_cnt`=1.
- Load pat_in=8'hFF, len_in=8, then stream 8 ones → pulse after bit 8. Continue with ones, overlap=1 → pulse every cycle. len_in=15 clamps to 8 with the same result.
- Gap handling: insert x_valid=0 cycles inside 10110 → match still detected; `z`=0 during gaps. Assert `pat_load` mid-pattern → partial history discarded, no pulse.
- Counter: CNT_W=2, 5 matches → `match_cnt` saturates at 3. `cnt_clr` coincident with a match → `match_cnt`=0, `z`=1.
- Async reset: pull `rst_n` low between clock edges mid-pattern → all outputs 0 immediately. After release, the pattern is back at 10110 with len 5.
